// File: rtl/adxl362_spi_responder.sv
// ADXL362-style SPI responder: mode-0 SPI slave exposing ID registers,
// acceleration samples, a STATUS register and a small writable RAM window.
// Optional build macro ADXL_DRDY_INT_EN drives INT1 from DATA_READY gated by
// INTMAP1 bit 0 (RAM address 0x2A); without it INT1 is tied low.
`timescale 1ns/1ps

module adxl362_spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        Clock_100MHz,
  input  logic        Reset_n,
  input  logic        SCLK,
  input  logic        CS,
  input  logic        MOSI,
  output logic        MISO,
  input  logic        sample_valid,
  input  logic [11:0] x_data,
  input  logic [11:0] y_data,
  input  logic [11:0] z_data,
  output logic        INT1,
  output logic        cmd_error
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} stateT;

  stateT state_q, state_d;

  logic [SYNC_STAGES-1:0] sclkSync_q, csSync_q, mosiSync_q;
  logic [SYNC_STAGES:0]   flush_q;
  logic                   sclkPrev_q, csPrev_q, armed_q;
  logic                   sclkS, csS, mosiS, sclkRise, sclkFall, csFall;

  logic [2:0] bitCnt_q, bitCnt_d;
  logic [7:0] shiftIn_q, rxByte;
  logic       cmdErr_q, cmdErr_d;
  logic       cmdOk, addrLoad, byteDone;

  logic       isRead_q, loadNext_q, loaded_q;
  logic [7:0] ptr_q, curAddr_q, misoShift_q, rdData;
  logic       ramHit;
  logic [7:0] ram_q [0:14];

  logic [11:0] xReg_q, yReg_q, zReg_q, xPend_q, yPend_q, zPend_q;
  logic        pend_q, dataReady_q, sampleApply, drClear;

  assign sclkS  = sclkSync_q[SYNC_STAGES-1];
  assign csS    = csSync_q[SYNC_STAGES-1];
  assign mosiS  = mosiSync_q[SYNC_STAGES-1];
  assign sclkRise = sclkS & ~sclkPrev_q;
  assign sclkFall = ~sclkS & sclkPrev_q;
  // A falling CS only counts once the synchronizer has seen a real high level
  // after reset, so a CS held low across reset never starts a transfer.
  assign csFall = armed_q & csPrev_q & ~csS;

  assign rxByte = {shiftIn_q[6:0], mosiS};
  assign ramHit = (ptr_q >= 8'h20) && (ptr_q <= 8'h2E);

  // Input synchronizers, edge-detect history and post-reset arming of CS.
  always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
    if (!Reset_n) begin
      sclkSync_q <= '0;
      csSync_q   <= '1;
      mosiSync_q <= '0;
      sclkPrev_q <= 1'b0;
      csPrev_q   <= 1'b1;
      flush_q    <= '0;
      armed_q    <= 1'b0;
    end else begin
      sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], SCLK};
      csSync_q   <= {csSync_q[SYNC_STAGES-2:0], CS};
      mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], MOSI};
      sclkPrev_q <= sclkS;
      csPrev_q   <= csS;
      flush_q    <= {flush_q[SYNC_STAGES-1:0], 1'b1};
      armed_q    <= armed_q | (flush_q[SYNC_STAGES] & csS);
    end
  end

  // FSM state, bit counter and the registered command-error pulse.
  always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      bitCnt_q <= '0;
      cmdErr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      cmdErr_q <= cmdErr_d;
    end
  end

  // Next-state decode and per-byte strobes; CS high always returns to IDLE.
  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    cmdErr_d = 1'b0;
    cmdOk    = 1'b0;
    addrLoad = 1'b0;
    byteDone = 1'b0;
    if (csS) begin
      state_d  = IDLE;
      bitCnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (csFall) begin
            state_d  = CMD;
            bitCnt_d = '0;
          end
        end
        CMD: begin
          if (sclkRise) begin
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              if (rxByte == 8'h0A || rxByte == 8'h0B) begin
                state_d = ADDR;
                cmdOk   = 1'b1;
              end else begin
                state_d  = IGNORE;
                cmdErr_d = 1'b1;
              end
            end
          end
        end
        ADDR: begin
          if (sclkRise) begin
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              state_d  = DATA;
              addrLoad = 1'b1;
            end
          end
        end
        DATA: begin
          if (sclkRise) begin
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) byteDone = 1'b1;
          end
        end
        IGNORE: begin
          state_d = IGNORE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Read-side register map; unmapped addresses return zero.
  always_comb begin
    rdData = 8'h00;
    case (ptr_q)
      8'h00: rdData = 8'hAD;
      8'h01: rdData = 8'h1D;
      8'h02: rdData = 8'hF2;
      8'h03: rdData = 8'h01;
      8'h08: rdData = xReg_q[11:4];
      8'h09: rdData = yReg_q[11:4];
      8'h0A: rdData = zReg_q[11:4];
      8'h0B: rdData = {7'b0, dataReady_q};
      8'h0E: rdData = xReg_q[7:0];
      8'h0F: rdData = {{4{xReg_q[11]}}, xReg_q[11:8]};
      8'h10: rdData = yReg_q[7:0];
      8'h11: rdData = {{4{yReg_q[11]}}, yReg_q[11:8]};
      8'h12: rdData = zReg_q[7:0];
      8'h13: rdData = {{4{zReg_q[11]}}, zReg_q[11:8]};
      default: if (ramHit) rdData = ram_q[ptr_q[3:0]];
    endcase
  end

  // Transaction datapath: shift-in, pointer, RAM writes and the MISO shifter.
  always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
    if (!Reset_n) begin
      shiftIn_q   <= '0;
      isRead_q    <= 1'b0;
      loadNext_q  <= 1'b0;
      loaded_q    <= 1'b0;
      ptr_q       <= '0;
      curAddr_q   <= '0;
      misoShift_q <= '0;
      for (int i = 0; i < 15; i++) ram_q[i] <= 8'h00;
    end else begin
      if (sclkRise) shiftIn_q <= rxByte;
      if (cmdOk) isRead_q <= rxByte[0];
      if (csS) begin
        loadNext_q  <= 1'b0;
        loaded_q    <= 1'b0;
        misoShift_q <= '0;
      end else if (addrLoad) begin
        ptr_q      <= rxByte;
        loadNext_q <= isRead_q;
      end else if (byteDone) begin
        if (isRead_q) begin
          loadNext_q <= 1'b1;
        end else begin
          if (ramHit) ram_q[ptr_q[3:0]] <= rxByte;
          ptr_q <= ptr_q + 8'd1;
        end
      end else if (sclkFall && state_q == DATA && isRead_q) begin
        if (loadNext_q) begin
          misoShift_q <= rdData;
          curAddr_q   <= ptr_q;
          loaded_q    <= 1'b1;
          loadNext_q  <= 1'b0;
          ptr_q       <= ptr_q + 8'd1;
        end else begin
          misoShift_q <= {misoShift_q[6:0], 1'b0};
        end
      end
    end
  end

  // Samples only land while CS is high; otherwise the newest one waits.
  assign sampleApply = (sample_valid | pend_q) & csS;
  assign drClear = byteDone & isRead_q & loaded_q &
                   ((curAddr_q == 8'h08) || (curAddr_q == 8'h0E));

  // Sample registers, pending sample holding and the DATA_READY flag.
  always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
    if (!Reset_n) begin
      xReg_q      <= '0;
      yReg_q      <= '0;
      zReg_q      <= '0;
      xPend_q     <= '0;
      yPend_q     <= '0;
      zPend_q     <= '0;
      pend_q      <= 1'b0;
      dataReady_q <= 1'b0;
    end else begin
      if (sample_valid && csS) begin
        xReg_q <= x_data;
        yReg_q <= y_data;
        zReg_q <= z_data;
        pend_q <= 1'b0;
      end else if (sample_valid) begin
        xPend_q <= x_data;
        yPend_q <= y_data;
        zPend_q <= z_data;
        pend_q  <= 1'b1;
      end else if (pend_q && csS) begin
        xReg_q <= xPend_q;
        yReg_q <= yPend_q;
        zReg_q <= zPend_q;
        pend_q <= 1'b0;
      end
      if (sampleApply) dataReady_q <= 1'b1;
      else if (drClear) dataReady_q <= 1'b0;
    end
  end

  assign MISO      = ~CS & (state_q == DATA) & isRead_q & misoShift_q[7];
  assign cmd_error = cmdErr_q;

`ifdef ADXL_DRDY_INT_EN
  assign INT1 = dataReady_q & ram_q[4'd10][0];
`else
  assign INT1 = 1'b0;
`endif

endmodule

// File: tb/tb_adxl362_spi_responder.sv
// Scoreboard bench for adxl362_spi_responder: stimulus queues expected bytes,
// a monitor pairs them with observed MISO bytes and output probes.
`timescale 1ns/1ps

module tb_adxl362_spi_responder;

  logic        clk = 1'b0;
  logic        rstN;
  logic        sclk, csN, mosi, sampleValid;
  logic [11:0] xData, yData, zData;
  logic        miso, int1, cmdErr;

  string       expNameQ[$];
  logic [7:0]  expValQ[$];
  logic [7:0]  obsQ[$];
  int          checks = 0;
  int          failures = 0;
  int          cmdErrCount = 0;
  bit          misoWatch = 1'b0;
  bit          misoSeen = 1'b0;
  bit          done = 1'b0;

`ifdef ADXL_DRDY_INT_EN
  localparam logic [7:0] INT1_EXP = 8'h01;
`else
  localparam logic [7:0] INT1_EXP = 8'h00;
`endif

  adxl362_spi_responder #(.SYNC_STAGES(2)) dut (
    .Clock_100MHz(clk),
    .Reset_n(rstN),
    .SCLK(sclk),
    .CS(csN),
    .MOSI(mosi),
    .MISO(miso),
    .sample_valid(sampleValid),
    .x_data(xData),
    .y_data(yData),
    .z_data(zData),
    .INT1(int1),
    .cmd_error(cmdErr)
  );

  always #5 clk = ~clk;

  // Counts cmd_error pulse cycles and watches MISO during quiet windows.
  always @(negedge clk) begin
    if (cmdErr === 1'b1) cmdErrCount++;
    if (misoWatch && miso !== 1'b0) misoSeen = 1'b1;
  end

  task pushExpected(input string name, input logic [7:0] value);
    expNameQ.push_back(name);
    expValQ.push_back(value);
  endtask

  task observe(input logic [7:0] value);
    obsQ.push_back(value);
  endtask

  task waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task spiBits(input logic [7:0] b, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      waitClk(8);
      rx = {rx[6:0], miso};
      sclk = 1'b1;
      waitClk(8);
      sclk = 1'b0;
    end
  endtask

  task spiByte(input logic [7:0] b, input bit capture);
    logic [7:0] rx;
    spiBits(b, 8, rx);
    if (capture) observe(rx);
  endtask

  task csAssert;
    csN = 1'b0;
    waitClk(8);
  endtask

  task csRelease;
    waitClk(8);
    csN = 1'b1;
    waitClk(12);
  endtask

  task readReg(input logic [7:0] addr, input int n);
    csAssert();
    spiByte(8'h0B, 1'b0);
    spiByte(addr, 1'b0);
    for (int i = 0; i < n; i++) spiByte(8'h00, 1'b1);
    csRelease();
  endtask

  task readExpect(input logic [7:0] addr, input string name, input logic [7:0] value);
    pushExpected(name, value);
    readReg(addr, 1);
  endtask

  task writeReg(input logic [7:0] addr, input logic [7:0] d0, input logic [7:0] d1, input int n);
    csAssert();
    spiByte(8'h0A, 1'b0);
    spiByte(addr, 1'b0);
    spiByte(d0, 1'b0);
    if (n > 1) spiByte(d1, 1'b0);
    csRelease();
  endtask

  task applySample(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z);
    xData = x;
    yData = y;
    zData = z;
    sampleValid = 1'b1;
    waitClk(1);
    sampleValid = 1'b0;
    waitClk(3);
  endtask

  task probeOutputs;
    @(negedge clk);
    observe({5'b0, miso, int1, cmdErr});
    waitClk(1);
  endtask

  task probeInt1;
    @(negedge clk);
    observe({7'b0, int1});
    waitClk(1);
  endtask

  // Monitor: pairs every observation with the oldest expectation.
  task checkOutput;
    logic [7:0] act, req;
    string      name;
    forever begin
      @(negedge clk);
      while (obsQ.size() > 0) begin
        act = obsQ.pop_front();
        checks++;
        if (expValQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_observation actual=0x%02h required=none", act);
        end else begin
          req  = expValQ.pop_front();
          name = expNameQ.pop_front();
          if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%02h required=0x%02h", name, act, req);
          end
        end
      end
    end
  endtask

  initial checkOutput();

  // Stimulus: directed transactions, expectations queued ahead of each.
  task applyStimulus;
    logic [7:0] rx;
    int base;
    rstN = 1'b0; csN = 1'b1; sclk = 1'b0; mosi = 1'b0;
    sampleValid = 1'b0; xData = '0; yData = '0; zData = '0;
    waitClk(3);
    pushExpected("reset_outputs", 8'h00);
    probeOutputs();
    rstN = 1'b1;
    waitClk(10);

    readExpect(8'h0B, "status_after_reset", 8'h00);
    pushExpected("devid_ad", 8'hAD);
    pushExpected("devid_mst", 8'h1D);
    readReg(8'h00, 2);
    pushExpected("partid", 8'hF2);
    pushExpected("revid", 8'h01);
    readReg(8'h02, 2);

    writeReg(8'h2D, 8'h02, 8'h00, 1);
    readExpect(8'h2D, "ram_write_2d", 8'h02);
    writeReg(8'h05, 8'h55, 8'h00, 1);
    readExpect(8'h05, "write_unmapped_05", 8'h00);
    writeReg(8'h2E, 8'h77, 8'h88, 2);
    pushExpected("ram_top_2e", 8'h77);
    pushExpected("past_ram_2f", 8'h00);
    readReg(8'h2E, 2);

    pushExpected("ptr_ff", 8'h00);
    pushExpected("ptr_wrap_00", 8'hAD);
    readReg(8'hFF, 2);

    applySample(12'h801, 12'h123, 12'hFED);
    readExpect(8'h0B, "drdy_set", 8'h01);
    pushExpected("xlow_0e", 8'h01);
    pushExpected("xhigh_0f", 8'hF8);
    readReg(8'h0E, 2);
    readExpect(8'h0B, "drdy_clr_0e", 8'h00);

    applySample(12'h801, 12'h123, 12'hFED);
    pushExpected("burst_08", 8'h80);
    pushExpected("burst_09", 8'h12);
    pushExpected("burst_0a", 8'hFE);
    pushExpected("burst_status_cleared", 8'h00);
    pushExpected("burst_0c", 8'h00);
    pushExpected("burst_0d", 8'h00);
    pushExpected("burst_0e", 8'h01);
    pushExpected("burst_0f", 8'hF8);
    pushExpected("burst_10", 8'h23);
    pushExpected("burst_11", 8'h01);
    pushExpected("burst_12", 8'hED);
    pushExpected("burst_13", 8'hFF);
    readReg(8'h08, 12);
    readExpect(8'h0B, "drdy_clr_08", 8'h00);

    csAssert();
    spiByte(8'h0B, 1'b0);
    spiByte(8'h08, 1'b0);
    applySample(12'h456, 12'h123, 12'hFED);
    applySample(12'h789, 12'h123, 12'hFED);
    pushExpected("held_old_08", 8'h80);
    spiByte(8'h00, 1'b1);
    csRelease();
    readExpect(8'h0B, "pending_drdy", 8'h01);
    readExpect(8'h08, "pending_newest_08", 8'h78);

    writeReg(8'h2A, 8'h01, 8'h00, 1);
    applySample(12'h801, 12'h123, 12'hFED);
    pushExpected("int1_set", INT1_EXP);
    probeInt1();
    readExpect(8'h08, "int1_read_08", 8'h80);
    pushExpected("int1_clear", 8'h00);
    probeInt1();

    pushExpected("no_spurious_cmd_error", 8'h00);
    observe(8'(cmdErrCount));
    base = cmdErrCount;
    misoSeen = 1'b0;
    misoWatch = 1'b1;
    csAssert();
    spiByte(8'h0D, 1'b0);
    pushExpected("ignore_byte", 8'h00);
    spiByte(8'h00, 1'b1);
    csRelease();
    misoWatch = 1'b0;
    pushExpected("cmd_error_pulses", 8'h01);
    observe(8'(cmdErrCount - base));
    pushExpected("ignore_miso_quiet", 8'h00);
    observe({7'b0, misoSeen});

    csAssert();
    spiByte(8'h0A, 1'b0);
    spiByte(8'h20, 1'b0);
    spiBits(8'hFF, 5, rx);
    csRelease();
    readExpect(8'h20, "partial_discard", 8'h00);
    writeReg(8'h20, 8'h3C, 8'h00, 1);
    readExpect(8'h20, "ram_write_20", 8'h3C);

    applySample(12'h801, 12'h123, 12'hFED);
    csAssert();
    spiByte(8'h0B, 1'b0);
    spiByte(8'h00, 1'b0);
    spiBits(8'h00, 3, rx);
    rstN = 1'b0;
    waitClk(2);
    pushExpected("reset_midburst", 8'h00);
    probeOutputs();
    rstN = 1'b1;
    waitClk(10);
    misoSeen = 1'b0;
    misoWatch = 1'b1;
    spiByte(8'h0B, 1'b0);
    spiByte(8'h00, 1'b0);
    pushExpected("no_decode_after_reset", 8'h00);
    spiByte(8'h00, 1'b1);
    csRelease();
    misoWatch = 1'b0;
    pushExpected("quiet_after_reset", 8'h00);
    observe({7'b0, misoSeen});
    readExpect(8'h00, "fresh_cs_decode", 8'hAD);
    readExpect(8'h2A, "ram_reset_2a", 8'h00);
    readExpect(8'h0B, "drdy_reset", 8'h00);
    readExpect(8'h08, "sample_reset", 8'h00);
    pushExpected("int1_after_reset", 8'h00);
    probeInt1();
  endtask

  initial begin
    applyStimulus();
    waitClk(4);
    if (expValQ.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL missing_observations actual=%0d required=0", expValQ.size());
    end
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so a stuck run still reports and terminates.
  initial begin
    #3_000_000;
    if (!done) begin
      failures++;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

endmodule

// File: doc/adxl362_spi_responder.md
ADXL362_SPI_RESPONDER -- requirements
Module: adxl362_spi_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth on SCLK, CS, MOSI; legal range 2..4.
REQ-002 Clock_100MHz  in  1  system clock; all logic on its rising edge.
REQ-003 Reset_n  in  1  reset, asynchronous assert, active-low.
REQ-004 SCLK  in  1  SPI clock from master; mode 0 (CPOL=0, CPHA=0), frequency at most Clock_100MHz/8.
REQ-005 CS  in  1  active-low chip select.
REQ-006 MOSI  in  1  master-out data, MSB first.
REQ-007 MISO  out  1  slave-out data, MSB first; 0 whenever CS is high.
REQ-008 sample_valid  in  1  one-cycle strobe qualifying x_data, y_data, z_data.
REQ-009 x_data, y_data, z_data  in  12 each  two's-complement acceleration samples.
REQ-010 INT1  out  1  data-ready interrupt, active-high (see Configuration).
REQ-011 cmd_error  out  1  one-cycle pulse when a command byte other than 0x0A or 0x0B completes.

Function
REQ-012 SCLK, CS and MOSI shall pass through SYNC_STAGES flops; SCLK edges are detected from the synchronized value.
REQ-013 FSM states: IDLE, CMD, ADDR, DATA, IGNORE.
- CS falling: enter CMD, bit counter = 0.
- CS high in any state: return to IDLE on the next cycle and discard any partial byte.
REQ-014 MOSI shall be sampled on synchronized SCLK rising edges.
- CMD: 8th bit completes the command byte. 0x0A (write) or 0x0B (read) goes to ADDR; any other value goes to IGNORE and pulses cmd_error.
- ADDR: 8th bit loads the 8-bit address pointer, then go to DATA.
REQ-015 Write transactions: each completed data byte writes reg[ptr] if ptr is in 0x20..0x2E; other addresses are ignored. ptr then increments.
REQ-016 Read transactions: the byte at reg[ptr] shall load into the MISO shifter on the SCLK falling edge that follows the last address bit, and after each subsequent completed byte. MISO shifts on each falling edge. ptr increments once per byte.
REQ-017 ptr shall wrap from 0xFF to 0x00 with no error.
REQ-018 Register map (read); unlisted addresses read 0x00.
- 0x00=0xAD, 0x01=0x1D, 0x02=0xF2, 0x03=0x01.
- 0x08/0x09/0x0A = x/y/z[11:4].
- 0x0B = STATUS, bit0 DATA_READY.
- 0x0E/0x0F = X low byte / {4 sign bits, x[11:8]}; 0x10/0x11 = Y; 0x12/0x13 = Z in the same format.
- 0x20..0x2E = writable RAM, reset 0x00.
REQ-019 Sample registers shall update the cycle after sample_valid if CS is high.
- If CS is low, the sample is held pending and applied on the cycle after CS rises.
- A newer sample overwrites a pending one.
- sample_valid coincident with the CS rise: the new sample is applied.
REQ-020 DATA_READY shall set when a sample is applied and clear when byte 0x08 or 0x0E has fully shifted out in a read. Set and clear in the same cycle: set wins.
REQ-021 IGNORE: MISO = 0 and no register changes until CS rises.

Reset
REQ-022 Reset_n low shall force within the same cycle:
- FSM to IDLE, MISO = 0, INT1 = 0, cmd_error = 0.
- DATA_READY = 0, sample registers = 0, RAM = 0x00.
- Synchronizers to idle (SCLK = 0, CS = 1).
REQ-023 Reset mid-transaction shall abort it. After release, no transfer is decoded until a fresh CS falling edge.

Configuration
REQ-024 Macro ADXL_DRDY_INT_EN:
- Defined: INT1 = DATA_READY AND RAM bit 0x2A[0] (INTMAP1 DATA_READY enable).
- Undefined: INT1 is tied to 0 and no logic is generated for it. DATA_READY in STATUS is unaffected.

Verification
REQ-025 Read of 0x00 (CS low; 0x0B, 0x00, 2 dummy bytes) -> MISO returns 0xAD then 0x1D.
REQ-026 Write (0x0A, 0x2D, 0x02) then read of 0x2D -> 0x02; write to 0x05 -> reads 0x00.
REQ-027 sample x=0x801 with CS high, then burst read from 0x0E -> 0x01, 0xF8; DATA_READY 1 before the read, 0 after.
REQ-028 sample_valid while CS is low during a read of 0x08 -> old value read; new value appears after CS rises.
REQ-029 Command 0x0D -> cmd_error pulses once and MISO stays 0; CS raised after 5 bits of a write byte -> no register change.
REQ-030 With ADXL_DRDY_INT_EN, 0x2A=0x01 and a sample applied -> INT1=1; read of 0x08 -> INT1=0; reset mid-burst -> all outputs 0.
